vppm_tx: RTL
============

VPPM_TX -- requirements
Module: vppm_tx

Interface
REQ-001 SHALL have parameter SYM_LEN, default 400, meaning clocks per VPPM symbol (8 us at 50 MHz clk).
REQ-002 SHALL have parameter DUTY_W, default 9, meaning width of duty_in; clog2(SYM_LEN) <= DUTY_W.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port duty_in  in  DUTY_W  requested pulse width in clocks (dimming level).
REQ-006 SHALL have port data_in  in  8  byte to transmit.
REQ-007 SHALL have port data_valid  in  1  data_in valid.
REQ-008 SHALL have port data_ready  out  1  holding register empty; byte accepted when data_valid && data_ready.
REQ-009 SHALL have port led_out  out  1  registered VPPM waveform to LED driver.
REQ-010 SHALL have port sym_strobe  out  1  one-clock pulse on the first clock of every symbol.
REQ-011 SHALL have port busy  out  1  high while a data symbol is on led_out.
REQ-012 SHALL have port bit_out  out  1  data bit of the current symbol (0 when idle), debug.
REQ-013 SHALL have port sym_cnt  out  DUTY_W  position within current symbol, 0..SYM_LEN-1, debug.

Function
REQ-014 SHALL free-run sym_cnt 0..SYM_LEN-1, wrapping to 0; wrap is the symbol boundary; sym_strobe=1 when sym_cnt==0.
REQ-015 SHALL latch d = min(duty_in, SYM_LEN) at each boundary; duty_in changes mid-symbol have no effect until the next symbol.
REQ-016 SHALL drive led_out, for bit 0 or idle: high while sym_cnt < d; for bit 1: high while sym_cnt >= SYM_LEN-d.
REQ-017 SHALL give d=0 -> led_out constantly low; d=SYM_LEN -> constantly high (data not recoverable, accepted).
REQ-018 SHALL implement FSM states IDLE and SEND; IDLE emits bit-0-shaped symbols so average brightness equals d/SYM_LEN.
REQ-019 SHALL keep a one-byte holding register; data_ready = not hold_full, registered.
REQ-020 SHALL, at each boundary: if SEND and bit_cnt<7, advance bit_cnt; else if hold_full, load shift register from hold, clear hold_full, enter SEND with bit_cnt=0; else enter IDLE.
REQ-021 SHALL transmit MSB first, one bit per symbol, 8 symbols per byte, back-to-back bytes without idle gap.
REQ-022 SHALL accept a byte at most once per clock; data_ready is low the clock after acceptance, so acceptance and load never coincide on the same byte.
REQ-023 SHALL start the first data symbol at the first boundary after acceptance (latency 1..SYM_LEN clocks).
REQ-024 SHALL ignore data_valid while data_ready=0; data_in is not sampled then.
REQ-025 SHALL assert busy and bit_out combinationally with the symbol they describe, aligned to led_out.
REQ-026 SHALL register led_out; one clock of pipeline delay relative to sym_cnt is allowed only if sym_strobe is delayed equally.

Reset
REQ-027 SHALL on rst=1 asynchronously set: sym_cnt=0, state IDLE, bit_cnt=0, hold_full=0, shift=0, d=0, led_out=0, sym_strobe=0, busy=0, bit_out=0, data_ready=0 during reset and 1 from the first clock after release.
REQ-028 SHALL, on reset mid-byte, discard the byte in progress and the holding register; no partial symbol resumes.

Structure
REQ-029 SHALL place SYM_LEN default, DUTY_W default and FSM state encoding in shared package vppm_pkg, shared with the receiver.
REQ-030 SHALL implement sym_cnt/sym_strobe in one sub-module vppm_sym_timer; everything else in vppm_tx.

Verification (SYM_LEN=400, clk 20 ns)
REQ-031 SHALL cover idle: duty_in=100, no data -> led_out high for sym_cnt 0..99, low 100..399, busy=0, every symbol.
REQ-032 SHALL cover byte 0xA5 with duty_in=100 -> 8 symbols, pulse at 300..399 for bits 1 and 0..99 for bits 0, pattern 1,0,1,0,0,1,0,1, then idle.
REQ-033 SHALL cover back-to-back 0xFF then 0x00 with data_valid held high -> 16 contiguous data symbols, data_ready low exactly from acceptance to next load.
REQ-034 SHALL cover duty change 100->200 at sym_cnt=50 -> current symbol keeps 100-clock pulse, next symbol 200.
REQ-035 SHALL cover clamps: duty_in=0 -> led_out low; duty_in=511 -> led_out high; symbol timing unchanged.
REQ-036 SHALL cover rst asserted during bit 3 of a byte -> all outputs to reset values immediately; after release, idle symbols only, data_ready=1.

Source files
------------

// File: rtl/vppm_pkg.sv
// Shared VPPM definitions used by both the transmitter and the receiver:
// default symbol geometry and the FSM state encoding.
package vppm_pkg;

  localparam int SYM_LEN_DEF = 400;
  localparam int DUTY_W_DEF  = 9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } vppm_state_e;

endpackage

// File: rtl/vppm_sym_timer.sv
// Free-running symbol position counter. It also exposes the next count and the
// wrap flag, so the transmitter can register led_out in step with sym_cnt.
module vppm_sym_timer
  import vppm_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int DUTY_W  = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] sym_cnt,
  output logic [DUTY_W-1:0] cnt_next,
  output logic              wrap,
  output logic              sym_strobe
);

  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(SYM_LEN - 1);
  localparam logic [DUTY_W-1:0] ONE_CNT  = DUTY_W'(1);

  // next position and symbol-boundary detect
  always_comb begin
    wrap = (sym_cnt == LAST_CNT);
    if (wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = sym_cnt + ONE_CNT;
    end
  end

  // counter and strobe registers; the strobe marks the clock where sym_cnt reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt    <= '0;
      sym_strobe <= 1'b0;
    end else begin
      sym_cnt    <= cnt_next;
      sym_strobe <= wrap;
    end
  end

endmodule

// File: rtl/vppm_tx.sv
// VPPM transmitter: one-byte holding register, MSB-first bit serialiser and
// pulse shaper. led_out is computed from next-cycle state so it lines up with sym_cnt.
module vppm_tx
  import vppm_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int DUTY_W  = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              led_out,
  output logic              sym_strobe,
  output logic              busy,
  output logic              bit_out,
  output logic [DUTY_W-1:0] sym_cnt
);

  localparam logic [DUTY_W-1:0] SYM_LEN_D = DUTY_W'(SYM_LEN);
  localparam logic [DUTY_W:0]   SYM_LEN_X = (DUTY_W + 1)'(SYM_LEN);

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
    if (duty > SYM_LEN_D) begin
      clamp_duty = SYM_LEN_D;
    end else begin
      clamp_duty = duty;
    end
  endfunction

  logic [DUTY_W-1:0] cnt_next_s;
  logic              wrap_s;

  vppm_state_e       state_r, state_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [7:0]        shift_r, shift_s;
  logic [7:0]        hold_r, hold_s;
  logic              hold_full_r, hold_full_s;
  logic [DUTY_W-1:0] d_r, d_s;
  logic              accept_s, load_s, bit_next_s, led_s;
  logic [DUTY_W:0]   thresh_s;

  vppm_sym_timer #(
    .SYM_LEN (SYM_LEN),
    .DUTY_W  (DUTY_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .sym_cnt    (sym_cnt),
    .cnt_next   (cnt_next_s),
    .wrap       (wrap_s),
    .sym_strobe (sym_strobe)
  );

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      hold_r      <= 8'd0;
      hold_full_r <= 1'b0;
      d_r         <= '0;
      led_out     <= 1'b0;
      data_ready  <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      d_r         <= d_s;
      led_out     <= led_s;
      data_ready  <= ~hold_full_s;
    end
  end

  // next state: only symbol boundaries move the serialiser
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    load_s    = 1'b0;
    if (wrap_s) begin
      if ((state_r == ST_SEND) && (bit_cnt_r != 3'd7)) begin
        bit_cnt_s = bit_cnt_r + 3'd1;
        shift_s   = {shift_r[6:0], 1'b0};
      end else if (hold_full_r) begin
        state_s   = ST_SEND;
        bit_cnt_s = 3'd0;
        shift_s   = hold_r;
        load_s    = 1'b1;
      end else begin
        state_s   = ST_IDLE;
        bit_cnt_s = 3'd0;
        shift_s   = 8'd0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // holding register and duty latch; accept and load never hit the same byte
  always_comb begin
    accept_s = data_valid & data_ready;
    if (accept_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else if (load_s) begin
      hold_s      = hold_r;
      hold_full_s = 1'b0;
    end else begin
      hold_s      = hold_r;
      hold_full_s = hold_full_r;
    end
    if (wrap_s) begin
      d_s = clamp_duty(duty_in);
    end else begin
      d_s = d_r;
    end
  end

  // pulse shaper: bit 1 pulses at the symbol end, bit 0 and idle at the start
  always_comb begin
    case (state_s)
      ST_SEND: bit_next_s = shift_s[7];
      ST_IDLE: bit_next_s = 1'b0;
      default: bit_next_s = 1'b0;
    endcase
    thresh_s = SYM_LEN_X - {1'b0, d_s};
    if (bit_next_s) begin
      led_s = ({1'b0, cnt_next_s} >= thresh_s);
    end else begin
      led_s = (cnt_next_s < d_s);
    end
  end

  assign busy    = (state_r == ST_SEND);
  assign bit_out = (state_r == ST_SEND) & shift_r[7];

endmodule
